// File: rtl/cnn_layer_engine.sv
// rtl/cnn_layer_engine.sv - single-layer 3x3 conv / affine engine with OUT_CH parallel MAC lanes
//
// Purpose: computes one network layer over a captured input map. mode=0 runs a
// 3x3 convolution with zero padding of 1 for every output pixel; mode=1 runs a
// fully-connected pass over the flattened map into pixel 0. Each lane adds bias,
// rescales by FRAC, saturates to DATA_W and writes into the output map register.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   load, mode    start request and layer type (sampled only when not busy)
//   d             input map, element (c,y,x) at index (c*H+y)*W+x
//   bias          per-lane bias, lane o at [o*DATA_W +: DATA_W]
//   w_addr, w_en  weight ROM read request for tap k
//   w_data        ROM data for the tap requested on the previous cycle
//   busy, valid   run in progress / output map ready (level)
//   q             output map, element (o,y,x) at index (o*H+y)*W+x
//
// Build option: define CNN_LAYER_ENGINE_RELU_EN to clamp negative results to 0.
module cnn_layer_engine #(
  parameter int DATA_W  = 16,
  parameter int FRAC    = 8,
  parameter int IN_CH   = 4,
  parameter int OUT_CH  = 8,
  parameter int H       = 4,
  parameter int W       = 4,
  parameter int ACC_W   = 40,
  parameter int WADDR_W = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            load,
  input  logic                            mode,
  input  logic [IN_CH*H*W*DATA_W-1:0]     d,
  input  logic [OUT_CH*DATA_W-1:0]        bias,
  output logic [WADDR_W-1:0]              w_addr,
  output logic                            w_en,
  input  logic [OUT_CH*DATA_W-1:0]        w_data,
  output logic                            busy,
  output logic                            valid,
  output logic [OUT_CH*H*W*DATA_W-1:0]    q
);

  localparam int NPIX = H * W;
  localparam int NIN  = IN_CH * NPIX;
  localparam int NOUT = OUT_CH * NPIX;
  localparam int KW   = WADDR_W + 1;
  localparam int PW   = $clog2(NPIX) + 1;
  localparam int CW   = $clog2(IN_CH) + 1;

  localparam logic [KW-1:0] K_CONV      = KW'(9 * IN_CH);
  localparam logic [KW-1:0] K_AFF       = KW'(NIN);
  localparam logic [PW-1:0] P_LAST_CONV = PW'(NPIX - 1);
  localparam logic [PW-1:0] X_LAST      = PW'(W - 1);

  typedef enum logic [1:0] {IDLE, MAC, STORE, FINI} state_t;

  state_t                     state_q;
  logic                       mode_q;
  logic                       busy_q;
  logic                       valid_q;
  logic [KW-1:0]              k_q;
  logic [PW-1:0]              p_q;
  logic [PW-1:0]              py_q;
  logic [PW-1:0]              px_q;
  logic [CW-1:0]              tc_q;
  logic [1:0]                 tky_q;
  logic [1:0]                 tkx_q;
  logic [NIN*DATA_W-1:0]      in_q;
  logic signed [DATA_W-1:0]   op_q;
  logic signed [DATA_W-1:0]   op_d;
  logic signed [ACC_W-1:0]    acc_q [OUT_CH];
  logic [NOUT*DATA_W-1:0]     q_q;

  logic [KW-1:0]              k_last;
  logic [PW-1:0]              p_last;
  logic signed [2*DATA_W-1:0] prod [OUT_CH];
  logic signed [ACC_W-1:0]    sum  [OUT_CH];
  logic [DATA_W-1:0]          res  [OUT_CH];

  assign k_last = mode_q ? K_AFF : K_CONV;
  assign p_last = mode_q ? '0 : P_LAST_CONV;

  assign w_en   = (state_q == MAC) && (k_q < k_last);
  assign w_addr = w_en ? k_q[WADDR_W-1:0] : '0;

  assign busy  = busy_q;
  assign valid = valid_q;
  assign q     = q_q;

  // Operand for the tap currently being requested from the ROM. It is
  // registered into op_q so that it meets the ROM data one cycle later.
  // tc/tky/tkx track k as (channel, kernel row, kernel column) in conv mode.
  always_comb begin
    int iy;
    int ix;
    int idx;
    op_d = '0;
    iy   = int'(py_q) + int'(tky_q) - 1;
    ix   = int'(px_q) + int'(tkx_q) - 1;
    idx  = (int'(tc_q) * H + iy) * W + ix;
    if (mode_q) begin
      if (k_q < k_last) begin
        op_d = in_q[int'(k_q)*DATA_W +: DATA_W];
      end
    end else if (int'(tc_q) < IN_CH && iy >= 0 && iy < H && ix >= 0 && ix < W) begin
      op_d = in_q[idx*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    for (int o = 0; o < OUT_CH; o++) begin
      prod[o] = (2*DATA_W)'(op_q) * (2*DATA_W)'($signed(w_data[o*DATA_W +: DATA_W]));
    end
  end

  // Rescale, bias, saturate. The sum fits DATA_W exactly when all bits from
  // the DATA_W-1 position upward agree.
  always_comb begin
    for (int o = 0; o < OUT_CH; o++) begin
      sum[o] = (acc_q[o] >>> FRAC) + ACC_W'($signed(bias[o*DATA_W +: DATA_W]));
      if ((&sum[o][ACC_W-1:DATA_W-1]) || !(|sum[o][ACC_W-1:DATA_W-1])) begin
        res[o] = sum[o][DATA_W-1:0];
      end else if (sum[o][ACC_W-1]) begin
        res[o] = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
        res[o] = {1'b0, {(DATA_W-1){1'b1}}};
      end
`ifdef CNN_LAYER_ENGINE_RELU_EN
      if (res[o][DATA_W-1]) begin
        res[o] = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      k_q     <= '0;
      p_q     <= '0;
      py_q    <= '0;
      px_q    <= '0;
      tc_q    <= '0;
      tky_q   <= '0;
      tkx_q   <= '0;
      in_q    <= '0;
      op_q    <= '0;
      q_q     <= '0;
      for (int o = 0; o < OUT_CH; o++) begin
        acc_q[o] <= '0;
      end
    end else begin
      case (state_q)
        IDLE, FINI: begin
          if (load) begin
            state_q <= MAC;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
            mode_q  <= mode;
            in_q    <= d;
            k_q     <= '0;
            p_q     <= '0;
            py_q    <= '0;
            px_q    <= '0;
            tc_q    <= '0;
            tky_q   <= '0;
            tkx_q   <= '0;
            for (int o = 0; o < OUT_CH; o++) begin
              acc_q[o] <= '0;
            end
            // An affine run only produces pixel 0; blank the rest so the
            // map does not carry stale conv results.
            if (mode) begin
              for (int o = 0; o < OUT_CH; o++) begin
                for (int pix = 1; pix < NPIX; pix++) begin
                  q_q[(o*NPIX + pix)*DATA_W +: DATA_W] <= '0;
                end
              end
            end
          end
        end

        MAC: begin
          if (k_q < k_last) begin
            op_q <= op_d;
            if (tkx_q == 2'd2) begin
              tkx_q <= '0;
              if (tky_q == 2'd2) begin
                tky_q <= '0;
                tc_q  <= tc_q + 1'b1;
              end else begin
                tky_q <= tky_q + 1'b1;
              end
            end else begin
              tkx_q <= tkx_q + 1'b1;
            end
          end
          // k=0 has no ROM data yet; from k=1 on w_data pairs with op_q.
          if (k_q != '0) begin
            for (int o = 0; o < OUT_CH; o++) begin
              acc_q[o] <= acc_q[o] + {{(ACC_W-2*DATA_W){prod[o][2*DATA_W-1]}}, prod[o]};
            end
          end
          k_q <= k_q + 1'b1;
          if (k_q == k_last) begin
            state_q <= STORE;
          end
        end

        STORE: begin
          for (int o = 0; o < OUT_CH; o++) begin
            q_q[(o*NPIX + int'(p_q))*DATA_W +: DATA_W] <= res[o];
            acc_q[o] <= '0;
          end
          k_q   <= '0;
          tc_q  <= '0;
          tky_q <= '0;
          tkx_q <= '0;
          p_q   <= p_q + 1'b1;
          if (p_q == p_last) begin
            state_q <= FINI;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end else begin
            state_q <= MAC;
            if (px_q == X_LAST) begin
              px_q <= '0;
              py_q <= py_q + 1'b1;
            end else begin
              px_q <= px_q + 1'b1;
            end
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_layer_engine.sv
// tb/tb_cnn_layer_engine.sv - self-checking bench for cnn_layer_engine
module tb_cnn_layer_engine;

  localparam int DW   = 16;
  localparam int IC   = 4;
  localparam int OC   = 8;
  localparam int HH   = 4;
  localparam int WW   = 4;
  localparam int NPIX = HH * WW;
  localparam int NIN  = IC * NPIX;
  localparam int NOUT = OC * NPIX;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              load  = 1'b0;
  logic              mode  = 1'b0;
  logic [NIN*DW-1:0] d;
  logic [OC*DW-1:0]  bias;
  logic [OC*DW-1:0]  w_data;
  logic [7:0]        w_addr;
  logic              w_en;
  logic              busy;
  logic              valid;
  logic [NOUT*DW-1:0] q;

  logic [DW-1:0]     din    [NIN];
  logic [DW-1:0]     wrom   [256][OC];
  logic [DW-1:0]     bias_a [OC];
  logic [NOUT*DW-1:0] exp_q;
  logic              chk_en = 1'b0;

  int checks = 0;
  int errors = 0;

  cnn_layer_engine dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .mode   (mode),
    .d      (d),
    .bias   (bias),
    .w_addr (w_addr),
    .w_en   (w_en),
    .w_data (w_data),
    .busy   (busy),
    .valid  (valid),
    .q      (q)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NIN; i++) d[i*DW +: DW] = din[i];
    for (int o = 0; o < OC; o++) bias[o*DW +: DW] = bias_a[o];
  end

  // Synchronous weight ROM, one cycle of read latency.
  always @(posedge clk) begin
    if (w_en) begin
      for (int o = 0; o < OC; o++) w_data[o*DW +: DW] <= wrom[w_addr][o];
    end
  end

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic chk_q(input string name);
    int bad;
    bad = -1;
    checks++;
    for (int i = NOUT - 1; i >= 0; i--) begin
      if (q[i*DW +: DW] !== exp_q[i*DW +: DW]) bad = i;
    end
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: element %0d got 0x%h, expected 0x%h", name, bad,
               q[bad*DW +: DW], exp_q[bad*DW +: DW]);
    end
  endtask

  // Reference layer: plain sums over the kernel window / flattened map.
  task automatic model(input logic m);
    longint acc;
    longint r;
    int yy;
    int xx;
    exp_q = '0;
    for (int o = 0; o < OC; o++) begin
      for (int p = 0; p < NPIX; p++) begin
        acc = 0;
        if (m) begin
          for (int k = 0; k < NIN; k++)
            acc += longint'($signed(din[k])) * longint'($signed(wrom[k][o]));
        end else begin
          for (int c = 0; c < IC; c++)
            for (int ky = 0; ky < 3; ky++)
              for (int kx = 0; kx < 3; kx++) begin
                yy = p / WW + ky - 1;
                xx = p % WW + kx - 1;
                if (yy >= 0 && yy < HH && xx >= 0 && xx < WW)
                  acc += longint'($signed(din[(c*HH + yy)*WW + xx])) *
                         longint'($signed(wrom[c*9 + ky*3 + kx][o]));
              end
        end
        if (!m || p == 0) begin
          r = (acc >>> 8) + longint'($signed(bias_a[o]));
          if (r > 32767) r = 32767;
          if (r < -32768) r = -32768;
`ifdef CNN_LAYER_ENGINE_RELU_EN
          if (r < 0) r = 0;
`endif
          exp_q[(o*NPIX + p)*DW +: DW] = r[15:0];
        end
      end
    end
  endtask

  always @(negedge clk) begin
    chk("busy and valid together", longint'(busy & valid), 0);
    if (!w_en) chk("w_addr while w_en=0", longint'(w_addr), 0);
    if (valid && chk_en) chk_q("q vs model");
  end

  task automatic clear_w();
    for (int k = 0; k < 256; k++)
      for (int o = 0; o < OC; o++) wrom[k][o] = '0;
  endtask

  // Issue a load, optionally pulse load again mid-run, and measure latency.
  task automatic run(input logic m, input int lat, input int p1, input int p2);
    int n;
    @(posedge clk); #1;
    load = 1'b1;
    mode = m;
    @(posedge clk); #1;
    load = 1'b0;
    chk("busy after load", longint'(busy), 1);
    chk("valid drops after load", longint'(valid), 0);
    chk_en = 1'b1;
    n = 0;
    while (!valid && n < lat + 20) begin
      n++;
      if (n == p1 || n == p2) begin
        load = 1'b1;
        mode = ~m;
      end
      @(posedge clk); #1;
      load = 1'b0;
      mode = m;
    end
    chk("load-to-valid latency", longint'(n), longint'(lat));
    chk("busy low at valid", longint'(busy), 0);
  endtask

  initial begin
    for (int i = 0; i < NIN; i++) din[i] = '0;
    for (int o = 0; o < OC; o++) bias_a[o] = '0;
    clear_w();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", longint'(busy), 0);
    chk("reset valid", longint'(valid), 0);
    chk("reset w_en", longint'(w_en), 0);
    chk("reset w_addr", longint'(w_addr), 0);
    chk("reset q nonzero", longint'(|q), 0);
    rst_n = 1'b1;

    // Conv identity: centre tap 1.0 maps channel c onto lane c.
    for (int i = 0; i < NIN; i++) din[i] = DW'(i * 37 - 900);
    for (int c = 0; c < IC; c++) wrom[c*9 + 4][c] = 16'h0100;
    chk_en = 1'b0;
    model(1'b0);
    run(1'b0, 608, 0, 0);
    chk("identity q(1,2,3)", longint'(q[27*DW +: DW]), 16'h0063);
    chk("identity q(0,0,0)", longint'(q[0 +: DW]), 16'hFC7C);
    chk("identity q(3,3,3)", longint'(q[63*DW +: DW]), longint'(din[63]));
    chk("identity q(5,1,1)", longint'(q[(5*NPIX + 5)*DW +: DW]), 0);

    // Reset in the middle of a run clears everything including q.
    chk_en = 1'b0;
    @(posedge clk); #1;
    load = 1'b1;
    mode = 1'b0;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid-run reset busy", longint'(busy), 0);
    chk("mid-run reset valid", longint'(valid), 0);
    chk("mid-run reset q nonzero", longint'(|q), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(1'b0, 608, 0, 0);

    // Padding: all-ones map and weights count the in-range taps.
    chk_en = 1'b0;
    for (int i = 0; i < NIN; i++) din[i] = 16'h0100;
    for (int k = 0; k < 9 * IC; k++)
      for (int o = 0; o < OC; o++) wrom[k][o] = 16'h0100;
    model(1'b0);
    run(1'b0, 608, 0, 0);
    chk("pad q(0,0,0)", longint'(q[0 +: DW]), 16'h1000);
    chk("pad q(0,1,1)", longint'(q[5*DW +: DW]), 16'h2400);
    chk("pad q(0,0,1)", longint'(q[1*DW +: DW]), 16'h1800);
    chk("pad q(7,3,3)", longint'(q[127*DW +: DW]), 16'h1000);

    // Same run with stray load pulses (and mode flips) mid-run.
    chk_en = 1'b0;
    run(1'b0, 608, 5, 300);
    chk("ignored loads q(0,1,1)", longint'(q[5*DW +: DW]), 16'h2400);

    // Restart from FINI into affine mode with saturation.
    chk_en = 1'b0;
    for (int i = 0; i < NIN; i++) din[i] = 16'h7FFF;
    for (int k = 0; k < NIN; k++)
      for (int o = 0; o < OC; o++) wrom[k][o] = 16'h7FFF;
    model(1'b1);
    run(1'b1, 66, 0, 0);
    chk("affine sat lane0", longint'(q[0 +: DW]), 16'h7FFF);
    chk("affine sat lane7", longint'(q[(7*NPIX)*DW +: DW]), 16'h7FFF);
    chk("affine other pixel", longint'(q[5*DW +: DW]), 0);

    // Negative bias with zero weights.
    chk_en = 1'b0;
    clear_w();
    bias_a[0] = 16'hFF00;
    model(1'b1);
    run(1'b1, 66, 0, 0);
`ifdef CNN_LAYER_ENGINE_RELU_EN
    chk("neg bias lane0", longint'(q[0 +: DW]), 16'h0000);
`else
    chk("neg bias lane0", longint'(q[0 +: DW]), 16'hFF00);
`endif
    chk("neg bias lane1", longint'(q[(1*NPIX)*DW +: DW]), 0);

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnn_layer_engine.md
# cnn_layer_engine

Parametrised single-layer compute engine, successor to the fixed-size layer block. It performs either a 3×3 same-padded convolution or a fully-connected (affine) pass over a flattened feature map. The engine runs OUT_CH parallel MAC lanes and fetches weights from an external 1-cycle-latency ROM. It adds bias, rescales, saturates, and presents the whole output map with a level `valid`. It sits between the network-level layer sequencer, which drives `load`/`mode`, and the next layer's input register.

## Interface
- DATA_W, 16, signed fixed-point element width
- FRAC, 8, fractional bits (product rescale shift)
- IN_CH, 4, input channels
- OUT_CH, 8, output channels = parallel MAC lanes
- H, 4, feature-map height
- W, 4, feature-map width
- ACC_W, 40, signed accumulator width (≥ 2·DATA_W + clog2(IN_CH·H·W))
- WADDR_W, 8, weight-address width (≥ clog2(max(9·IN_CH, IN_CH·H·W)))

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- load  in  1  start request; sampled only when not busy
- mode  in  1  0 = conv 3×3 pad 1, 1 = affine; sampled with load
- d  in  IN_CH·H·W·DATA_W  input map; element (c,y,x) at index (c·H+y)·W+x, bits [idx·DATA_W +: DATA_W]
- bias  in  OUT_CH·DATA_W  lane o at [o·DATA_W +: DATA_W]; static during a run
- w_addr  out  WADDR_W  weight tap index k
- w_en  out  1  weight read strobe
- w_data  in  OUT_CH·DATA_W  weights for tap presented on the previous cycle, lane o at [o·DATA_W +: DATA_W]
- busy  out  1  run in progress
- valid  out  1  result ready, level
- q  out  OUT_CH·H·W·DATA_W  output map; element (o,y,x) at index (o·H+y)·W+x

## Operation
- FSM states: IDLE, MAC, STORE, FINI. Reset enters IDLE.
- IDLE/FINI + load=1 → MAC.
  - Captures d into the input buffer and mode into the mode register.
  - Clears pixel counter p, tap counter k, and all accumulators.
- Per-run constants:
  - conv: K = 9·IN_CH, P = H·W.
  - affine: K = IN_CH·H·W, P = 1.
- MAC (K+1 cycles per pixel):
  - While k<K: w_en=1 and w_addr=k.
  - While k≥1: each lane adds the product of x(k−1) and its w_data lane.
  - k increments each cycle. When k=K, go to STORE.
- Tap order in conv mode: k = c·9 + ky·3 + kx. The operand is the input at (py+ky−1, px+kx−1); out-of-range coordinates give operand 0 (zero padding).
- Tap order in affine mode: k = c·H·W + y·W + x, operand d element k.
- STORE (1 cycle), per lane o:
  - r = (acc >>> FRAC) + sign-extended bias[o].
  - r is saturated to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - The result is written to q element (o, py, px). In affine mode it goes to pixel 0.
  - Accumulators and k are cleared, p increments.
  - If p = P−1, go to FINI; otherwise go back to MAC.
- Pixel order p = py·W + px.
- In affine mode, q elements for pixels ≠ 0 are written 0 at run start.
- FINI: valid=1. It holds until the next accepted load, which re-enters MAC the same edge; valid drops the following cycle.
- load while in MAC or STORE is ignored. A mode change mid-run has no effect.
- Product width is 2·DATA_W signed. Accumulation wraps at ACC_W; overflow is prevented by parameter sizing, not detected.

## Timing
- Reset values: busy=0, valid=0, w_en=0, w_addr=0, q=0, accumulators 0, state IDLE.
- rst_n low mid-run aborts immediately to these values, including q.
- busy=1 in MAC and STORE. busy is registered state decode.
- valid=1 exactly in FINI.
- w_en and w_addr are combinational decodes of state and k. w_addr=0 when w_en=0.
- ROM contract: the w_data sampled at edge t+1 belongs to the w_addr driven in cycle t.
- Latency from the accepting load edge to valid=1 is P·(K+2) cycles.
  - Defaults, conv: 16·38 = 608 cycles.
  - Defaults, affine: 66 cycles.
- q updates only on STORE edges. q is stable whenever valid=1.

## Configuration
- CNN_LAYER_ENGINE_RELU_EN defined: STORE applies ReLU after saturation, so negative results are written as 0.
- Not defined: signed saturated values are written unchanged.

## Test plan
- Reset mid-run: load, then rst_n low for 1 cycle at cycle 100 → busy=0, valid=0, q=0. A fresh load then completes normally at +608.
- Conv identity (defaults):
  - Stimulus: only centre tap weight = 1.0 (0x0100) for o=c, c<4; all else 0; bias 0.
  - Required: q(o,y,x) = d(o,y,x) for o<4, 0 for o≥4; valid exactly 608 cycles after load.
- Padding corner:
  - Stimulus: d all 0x0100; all weights 0x0100; bias 0; ReLU off.
  - Required: q(0,0,0) = 4·4·1.0 = 0x1000; q(0,1,1) = 36·1.0 = 0x2400.
- Affine plus saturation:
  - Stimulus: mode=1, d all 0x7FFF, all weights 0x7FFF.
  - Required: every pixel-0 lane = 0x7FFF; other pixels 0; valid at +66.
- Negative bias and macro:
  - Stimulus: weights 0, bias lane 0 = 0xFF00.
  - Required: q lane 0 = 0xFF00 without CNN_LAYER_ENGINE_RELU_EN, 0x0000 with it.
- Busy and restart:
  - Stimulus: load pulses at cycles 5 and 300 during a run, then load while in FINI.
  - Required: the mid-run pulses are ignored. The load in FINI restarts, and valid drops the next cycle.
